pll_phase_stepper: RTL and testbench

Runtime phase-shift initiator for the Gowin GW5A `PLL` dynamic phase interface (`PSSEL`/`PSDIR`/`PSPULSE`). It replaces rebuild-per-trial tuning of the SDRAM clock phase (CLKOUT2) with runtime stepping. It accepts a target fine-phase position over a valid/ready handshake and emits spaced PSPULSE strobes. It tracks the current phase modulo one revolution and pauses while PLL lock is lost. It sits beside the SNES PLL wrapper in the top level and is driven by the OSD/config logic.

---
 rtl/pll_phase_stepper_pkg.sv | 25 ++
 rtl/pll_phase_stepper_if.sv | 31 +++
 rtl/pll_phase_stepper_lock_qualifier.sv | 47 ++++
 rtl/pll_phase_stepper.sv | 189 ++++++++++++++++++
 tb/tb_pll_phase_stepper.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_phase_stepper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_phase_pkg
// Purpose  : Shared state encoding and default sizing for pll_phase_stepper.
// Revision : 1.0 - initial release
// ============================================================================
package pll_phase_pkg;

  // Fine steps per revolution of CLKOUT2 (ODIV2 = 10, eight steps per ODIV)
  localparam int DEF_STEPS_PER_REV = 80;
  // Phase register width; 2^DEF_PW must cover DEF_STEPS_PER_REV
  localparam int DEF_PW            = 7;

  // Stepper control states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pll_phase_stepper_if.sv
`default_nettype none
// ============================================================================
// Module   : pll_phase_stepper_if
// Purpose  : Request/status bundle between the config logic (master) and the
//            phase stepper (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface pll_phase_stepper_if #(
  parameter int PW = 7
) ();

  logic          req_valid;
  logic [PW-1:0] req_phase;
  logic          req_ready;
  logic          req_err;
  logic          busy;
  logic          done;
  logic [PW-1:0] cur_phase;

  modport master (
    output req_valid, req_phase,
    input  req_ready, req_err, busy, done, cur_phase
  );

  modport slave (
    input  req_valid, req_phase,
    output req_ready, req_err, busy, done, cur_phase
  );

endinterface
`default_nettype wire

// File: rtl/pll_phase_stepper_lock_qualifier.sv
`default_nettype none
// ============================================================================
// Module   : lock_qualifier
// Purpose  : Two-flop synchroniser for PLL LOCK followed by a saturating
//            run-length counter; lock_ok is high once LOCK_WAIT consecutive
//            synchronised-high cycles have been seen and drops on any low.
// Revision : 1.0 - initial release
// ============================================================================
module lock_qualifier #(
  parameter int LOCK_WAIT = 8
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic pll_lock,
  output logic      lock_ok
);

  localparam int            CW     = $clog2(LOCK_WAIT + 1);
  localparam logic [CW-1:0] C_WAIT = CW'(LOCK_WAIT);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;

  // Bring the asynchronous LOCK level into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], pll_lock};
    end
  end

  // Count consecutive locked cycles, saturating at LOCK_WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!r_sync[1]) begin
      r_cnt <= '0;
    end else if (r_cnt != C_WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign lock_ok = (r_cnt == C_WAIT);

endmodule
`default_nettype wire

// File: rtl/pll_phase_stepper.sv
`default_nettype none
// ============================================================================
// Module   : pll_phase_stepper
// Purpose  : Runtime phase-shift initiator for the GW5A PLL dynamic phase
//            port. Accepts a target fine-phase over valid/ready, issues
//            spaced active-low PSPULSE strobes, tracks the phase modulo one
//            revolution and pauses between steps while lock is lost.
// Options  : PLL_PHASE_SHORTEST_EN - when defined, the direction is chosen to
//            minimise the step count (tie goes forward); otherwise every
//            move steps forward.
// Revision : 1.0 - initial release
// ============================================================================
module pll_phase_stepper
  import pll_phase_pkg::*;
#(
  parameter int SEL           = 2,
  parameter int STEPS_PER_REV = DEF_STEPS_PER_REV,
  parameter int PULSE_W       = 4,
  parameter int GAP           = 16,
  parameter int LOCK_WAIT     = 8,
  parameter int PW            = DEF_PW
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               pll_lock,
  pll_phase_stepper_if.slave      req_if,
  output logic [2:0]              ps_sel,
  output logic                    ps_dir,
  output logic                    ps_pulse
);

  // One timer serves both PULSE and GAP, so size it for the longer of the two
  localparam int            TMAX         = (PULSE_W > GAP) ? PULSE_W : GAP;
  localparam int            TW           = $clog2(TMAX + 1);
  localparam logic [TW-1:0] C_PULSE_LAST = TW'(PULSE_W - 1);
  localparam logic [TW-1:0] C_GAP_LAST   = TW'(GAP - 1);
  localparam logic [PW:0]   C_STEPS      = (PW+1)'(STEPS_PER_REV);
  localparam logic [PW-1:0] C_LAST_PHASE = PW'(STEPS_PER_REV - 1);

  state_t        r_state, w_next;
  logic [TW-1:0] r_cnt, w_cnt_next;
  logic [PW:0]   r_rem, w_rem_next;
  logic [PW-1:0] r_cur, w_cur_next;
  logic          r_dir, w_dir_next;
  logic          r_err, w_err_next;
  logic          r_pulse;

  logic          w_lock_ok;
  logic          w_accept;
  logic          w_in_range;
  logic [PW:0]   w_sum;
  logic [PW:0]   w_fwd;
  logic          w_fwd_dir;
  logic [PW:0]   w_steps;

  lock_qualifier #(
    .LOCK_WAIT (LOCK_WAIT)
  ) u_lock_qualifier (
    .clk      (clk),
    .reset    (reset),
    .pll_lock (pll_lock),
    .lock_ok  (w_lock_ok)
  );

  // Forward distance (target - cur) mod STEPS_PER_REV in PW+1 bits; the
  // target is range-checked first, so the sum is below 2*STEPS_PER_REV
  assign w_in_range = ({1'b0, req_if.req_phase} < C_STEPS);
  assign w_sum      = {1'b0, req_if.req_phase} + C_STEPS - {1'b0, r_cur};
  assign w_fwd      = (w_sum >= C_STEPS) ? (w_sum - C_STEPS) : w_sum;

`ifdef PLL_PHASE_SHORTEST_EN
  localparam logic [PW:0] C_HALF = (PW+1)'(STEPS_PER_REV / 2);
  // Go backwards only when that is strictly shorter
  assign w_fwd_dir = (w_fwd <= C_HALF);
  assign w_steps   = w_fwd_dir ? w_fwd : (C_STEPS - w_fwd);
`else
  assign w_fwd_dir = 1'b1;
  assign w_steps   = w_fwd;
`endif

  assign w_accept = req_if.req_valid && (r_state == ST_IDLE) && w_lock_ok;

  // Next-state, step timer, remaining count and phase tracking
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_rem_next = r_rem;
    w_cur_next = r_cur;
    w_dir_next = r_dir;
    w_err_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!w_in_range) begin
            w_err_next = 1'b1;
          end else if (req_if.req_phase == r_cur) begin
            w_next = ST_DONE;
          end else begin
            w_dir_next = w_fwd_dir;
            w_rem_next = w_steps;
            w_next     = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        w_cnt_next = '0;
        w_next     = ST_PULSE;
      end
      ST_PULSE: begin
        if (r_cnt == C_PULSE_LAST) begin
          // Step is committed on the last low cycle
          if (r_dir) begin
            w_cur_next = (r_cur == C_LAST_PHASE) ? '0 : (r_cur + 1'b1);
          end else begin
            w_cur_next = (r_cur == '0) ? C_LAST_PHASE : (r_cur - 1'b1);
          end
          w_rem_next = r_rem - 1'b1;
          w_cnt_next = '0;
          w_next     = ST_GAP;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (!w_lock_ok) begin
          w_cnt_next = '0;
          w_next     = ST_HOLD;
        end else if (r_cnt == C_GAP_LAST) begin
          w_cnt_next = '0;
          w_next     = (r_rem != '0) ? ST_PULSE : ST_DONE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        // Restart a full gap once lock is trusted again
        if (w_lock_ok) begin
          w_cnt_next = '0;
          w_next     = ST_GAP;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Register the control state and datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_cur   <= '0;
      r_dir   <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_rem   <= w_rem_next;
      r_cur   <= w_cur_next;
      r_dir   <= w_dir_next;
      r_err   <= w_err_next;
    end
  end

  // Strobe to the PLL comes straight from a flop so it cannot glitch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pulse <= 1'b1;
    end else begin
      r_pulse <= (w_next != ST_PULSE);
    end
  end

  assign ps_sel           = 3'(SEL);
  assign ps_dir           = r_dir;
  assign ps_pulse         = r_pulse;
  assign req_if.req_ready = (r_state == ST_IDLE) && w_lock_ok;
  assign req_if.req_err   = r_err;
  assign req_if.busy      = (r_state != ST_IDLE);
  assign req_if.done      = (r_state == ST_DONE);
  assign req_if.cur_phase = r_cur;

endmodule
`default_nettype wire

// File: tb/tb_pll_phase_stepper.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_phase_stepper
// Purpose  : Self-checking bench for pll_phase_stepper: vector table,
//            lock-loss and reset sequences, and random targets against a
//            modular-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_phase_stepper;

  localparam int SEL       = 2;
  localparam int STEPS     = 80;
  localparam int PULSE_W   = 4;
  localparam int GAP       = 16;
  localparam int LOCK_WAIT = 8;
  localparam int PW        = 7;
  localparam int STEP_CYC  = PULSE_W + GAP;
  localparam int MAXLAT    = 2 + STEPS * STEP_CYC + 300;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic [2:0] ps_sel;
  logic       ps_dir;
  logic       ps_pulse;

  pll_phase_stepper_if #(.PW(PW)) rif ();

  pll_phase_stepper #(
    .SEL(SEL), .STEPS_PER_REV(STEPS), .PULSE_W(PULSE_W), .GAP(GAP),
    .LOCK_WAIT(LOCK_WAIT), .PW(PW)
  ) dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .req_if(rif),
    .ps_sel(ps_sel), .ps_dir(ps_dir), .ps_pulse(ps_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int low_len = 0;
  bit prev_pulse = 1'b1;
  bit mon_en = 1'b0;
  bit exp_dir = 1'b1;
  int m_cur = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Pulse monitor: count strobes, check direction and low width
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_pulse && !ps_pulse) begin
        pulse_cnt++;
        low_len = 1;
        checks++;
        if (ps_dir !== exp_dir) begin
          errors++;
          $display("FAIL pulse_dir: got %0b expected %0b", ps_dir, exp_dir);
        end
      end else if (!ps_pulse) begin
        low_len++;
      end else if (!prev_pulse) begin
        checks++;
        if (low_len != PULSE_W) begin
          errors++;
          $display("FAIL pulse_width: got %0d expected %0d", low_len, PULSE_W);
        end
      end
    end
    prev_pulse = ps_pulse;
  end

  // Reference: distances taken on the phase circle with plain arithmetic
  function automatic void ref_model(input int cur, input int tgt, output bit err,
                                    output int n, output bit dir, output int nxt);
    int fwd;
    err = (tgt >= STEPS);
    n = 0; dir = 1'b1; nxt = cur;
    if (!err) begin
      fwd = ((tgt - cur) % STEPS + STEPS) % STEPS;
`ifdef PLL_PHASE_SHORTEST_EN
      if (fwd <= STEPS / 2) begin n = fwd; dir = 1'b1; end
      else begin n = STEPS - fwd; dir = 1'b0; end
`else
      n = fwd; dir = 1'b1;
`endif
      nxt = tgt;
    end
  endfunction

  task automatic wait_ready(input string tag);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rif.req_ready) break;
    end
    if (k == 200) chk({tag, "_ready_timeout"}, 0, 1);
  endtask

  // Issue one request and check the whole transaction; exact latency when
  // lat_exact is set, otherwise it must include at least a lock requalify
  task automatic run_req(input int phase, input bit e_err, input int e_n, input bit e_dir,
                         input int e_cur, input bit lat_exact, input string tag);
    int k;
    int p0;
    int lat;
    bit seen;
    wait_ready(tag);
    exp_dir = e_dir;
    p0 = pulse_cnt;
    rif.req_valid = 1'b1;
    rif.req_phase = PW'(phase);
    @(posedge clk);
    @(negedge clk);
    rif.req_valid = 1'b0;
    rif.req_phase = PW'($urandom);
    if (e_err) begin
      chk({tag, "_req_err"}, rif.req_err, 1);
      chk({tag, "_err_busy"}, rif.busy, 0);
      chk({tag, "_err_cur"}, rif.cur_phase, e_cur);
      @(negedge clk);
      chk({tag, "_err_pulse1"}, rif.req_err, 0);
      chk({tag, "_err_ready"}, rif.req_ready, 1);
      return;
    end
    chk({tag, "_ready_drop"}, rif.req_ready, 0);
    chk({tag, "_busy"}, rif.busy, 1);
    seen = 1'b0;
    for (k = 1; k <= MAXLAT; k++) begin
      if (rif.done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, seen, 1);
    lat = (e_n == 0) ? 1 : 2 + e_n * STEP_CYC;
    if (lat_exact) chk({tag, "_latency"}, k, lat);
    else chk({tag, "_latency_min"}, (k >= lat + LOCK_WAIT) ? 1 : 0, 1);
    chk({tag, "_pulses"}, pulse_cnt - p0, e_n);
    chk({tag, "_cur"}, rif.cur_phase, e_cur);
    @(negedge clk);
    chk({tag, "_done_pulse1"}, rif.done, 0);
    chk({tag, "_idle"}, rif.busy, 0);
    chk({tag, "_ready_back"}, rif.req_ready, 1);
  endtask

  typedef struct {
    int phase;
    bit err;
    int n;
    bit dir;
    int cur;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit r_err;
    bit r_dir;
    int r_n;
    int r_nxt;
    int tgt;
    int pc;
    int k;

    // Targets from reset phase 0; expected values worked by hand
    tbl[0] = '{3,   1'b0, 3,  1'b1, 3};
    tbl[1] = '{3,   1'b0, 0,  1'b1, 3};
    tbl[2] = '{80,  1'b1, 0,  1'b1, 3};
    tbl[3] = '{127, 1'b1, 0,  1'b1, 3};
    tbl[4] = '{5,   1'b0, 2,  1'b1, 5};
    tbl[5] = '{5,   1'b0, 0,  1'b1, 5};
`ifdef PLL_PHASE_SHORTEST_EN
    tbl[6] = '{78,  1'b0, 7,  1'b0, 78};
    tbl[7] = '{1,   1'b0, 3,  1'b1, 1};
    tbl[8] = '{0,   1'b0, 1,  1'b0, 0};
`else
    tbl[6] = '{78,  1'b0, 73, 1'b1, 78};
    tbl[7] = '{1,   1'b0, 3,  1'b1, 1};
    tbl[8] = '{0,   1'b0, 79, 1'b1, 0};
`endif

    reset = 1'b1;
    pll_lock = 1'b1;
    rif.req_valid = 1'b0;
    rif.req_phase = '0;
    #23;
    chk("rst_ps_pulse", ps_pulse, 1);
    chk("rst_ps_dir", ps_dir, 1);
    chk("rst_ps_sel", ps_sel, SEL);
    chk("rst_cur", rif.cur_phase, 0);
    chk("rst_ready", rif.req_ready, 0);
    chk("rst_err", rif.req_err, 0);
    chk("rst_done", rif.done, 0);
    chk("rst_busy", rif.busy, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("requal_ready_early", rif.req_ready, 0);
    mon_en = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_req(tbl[i].phase, tbl[i].err, tbl[i].n, tbl[i].dir, tbl[i].cur, 1'b1,
              $sformatf("vec%0d", i));
    end
    m_cur = tbl[8].cur;

    // Lock lost for 3 cycles in the gap after the 2nd of 5 steps
    tgt = (m_cur + 5) % STEPS;
    pc = pulse_cnt;
    fork
      run_req(tgt, 1'b0, 5, 1'b1, tgt, 1'b0, "lockdrop");
      begin
        for (k = 0; k < 500; k++) begin
          @(negedge clk);
          if (pulse_cnt >= pc + 2 && ps_pulse) break;
        end
        chk("lockdrop_reach_gap", (k < 500) ? 1 : 0, 1);
        repeat (4) @(negedge clk);
        pc = pulse_cnt;
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        pll_lock = 1'b1;
        repeat (LOCK_WAIT) @(negedge clk);
        chk("lockdrop_no_pulse", pulse_cnt, pc);
      end
    join
    m_cur = tgt;

    // Reset while a pulse is low
    wait_ready("rstmid");
    tgt = (m_cur + 10) % STEPS;
    rif.req_valid = 1'b1;
    rif.req_phase = PW'(tgt);
    @(posedge clk);
    @(negedge clk);
    rif.req_valid = 1'b0;
    for (k = 0; k < 100; k++) begin
      if (!ps_pulse) break;
      @(negedge clk);
    end
    chk("rstmid_pulse_seen", (k < 100) ? 1 : 0, 1);
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rstmid_ps_pulse", ps_pulse, 1);
    chk("rstmid_cur", rif.cur_phase, 0);
    chk("rstmid_busy", rif.busy, 0);
    chk("rstmid_ready", rif.req_ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (k = 1; k < 100; k++) begin
      @(negedge clk);
      if (rif.req_ready) break;
    end
    chk("rstmid_requal_wait", (k >= LOCK_WAIT && k < 100) ? 1 : 0, 1);
    m_cur = 0;
    mon_en = 1'b1;

    // Random targets, some out of range, against the reference model
    for (int i = 0; i < 10; i++) begin
      tgt = (i == 0) ? 78 : int'($urandom_range(0, 95));
      ref_model(m_cur, tgt, r_err, r_n, r_dir, r_nxt);
      run_req(tgt, r_err, r_n, r_dir, r_nxt, 1'b1, $sformatf("rnd%0d", i));
      m_cur = r_nxt;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
